// File: rtl/pixel_main.sv
// pixel_main
// ----------
// Single-pixel point-operation engine for an 8-bit grayscale stream. One
// pixel is accepted on every rising edge, and the processed pixel appears
// on the registered output one clock later. There is no handshake, no stall
// and no frame awareness. The result depends only on the inputs sampled at
// that edge.
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   rst_n      asynchronous, active-low reset; forces outbyte to 8'h00
//   select     operation code:
//                00 = brighten (saturating add)
//                01 = darken (clamping subtract)
//                10 = binary threshold
//                11 = invert
//   value      brightness offset, used only by ops 00/01
//   threshold  threshold level, used only by op 10
//   inbyte     input pixel
//   outbyte    processed pixel (registered, one-cycle latency)

module pixel_main (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] select,
    input  logic [7:0] value,
    input  logic [7:0] threshold,
    input  logic [7:0] inbyte,
    output logic [7:0] outbyte
);

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_THR = 2'b10;
    localparam logic [1:0] OP_INV = 2'b11;

    // Saturating add. The carry out of the 9-bit sum means the true result
    // exceeded 255, so the output pins to full white.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[8]) begin
            sat_add = 8'hFF;
        end else begin
            sat_add = sum[7:0];
        end
    endfunction

    // Clamping subtract. Bit 8 of the 9-bit difference is the borrow
    // (a < b), so the output pins to black.
    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[8]) begin
            sat_sub = 8'h00;
        end else begin
            sat_sub = diff[7:0];
        end
    endfunction

    // Strictly-greater comparison. A pixel equal to the level maps to black.
    function automatic logic [7:0] binarize(input logic [7:0] a, input logic [7:0] lvl);
        if (a > lvl) begin
            binarize = 8'hFF;
        end else begin
            binarize = 8'h00;
        end
    endfunction

    logic [7:0] result_s;
    logic [7:0] outbyte_r;

    // Select the point operation for the pixel presented this cycle.
    always_comb begin
        result_s = 8'h00;
        case (select)
            OP_INC:  result_s = sat_add(inbyte, value);
            OP_DEC:  result_s = sat_sub(inbyte, value);
            OP_THR:  result_s = binarize(inbyte, threshold);
            OP_INV:  result_s = ~inbyte;
            default: result_s = 8'h00;
        endcase
    end

    // Output register. The asynchronous clear drops the pixel to black
    // without waiting for a clock edge. No other state exists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outbyte_r <= 8'h00;
        end else begin
            outbyte_r <= result_s;
        end
    end

    assign outbyte = outbyte_r;

endmodule

// File: tb/tb_pixel_main.sv
// Scoreboard bench for pixel_main. The stimulus side pushes one expected
// pixel per consumed edge. The monitor pops and compares one cycle later.
module tb_pixel_main;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] select = 2'b00;
    logic [7:0] value = 8'h00;
    logic [7:0] threshold = 8'h00;
    logic [7:0] inbyte = 8'h00;
    logic [7:0] outbyte;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    pixel_main dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .select    (select),
        .value     (value),
        .threshold (threshold),
        .inbyte    (inbyte),
        .outbyte   (outbyte)
    );

    always #5 clk = ~clk;

    // Reference model written as plain integer arithmetic.
    function automatic logic [7:0] ref_model(input logic [1:0] sel, input logic [7:0] val,
                                             input logic [7:0] thr, input logic [7:0] pix);
        int p, v, t, r;
        p = pix; v = val; t = thr;
        case (sel)
            2'd0:    r = (p + v > 255) ? 255 : p + v;
            2'd1:    r = (p - v < 0) ? 0 : p - v;
            2'd2:    r = (p > t) ? 255 : 0;
            default: r = 255 - p;
        endcase
        return r[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: outbyte=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Present one pixel at the falling edge. If the following rising edge
    // consumes it, queue its expected result. use_c selects a hand-computed
    // constant instead of the model.
    task automatic drive(input logic [1:0] sel, input logic [7:0] val, input logic [7:0] thr,
                         input logic [7:0] pix, input bit use_c, input logic [7:0] exp_c,
                         input string name);
        exp_t e;
        @(negedge clk);
        select = sel; value = val; threshold = thr; inbyte = pix;
        @(posedge clk);
        if (rst_n) begin
            e.exp  = use_c ? exp_c : ref_model(sel, val, thr, pix);
            e.name = name;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: one cycle of latency, so whatever was queued at this edge is
    // what outbyte must show now.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, outbyte, e.exp);
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dec_in [4];
        logic [7:0] dec_ex [4];
        logic [7:0] inc_in [4];
        logic [7:0] inc_ex [4];
        logic [7:0] thr_in [4];
        logic [7:0] thr_ex [4];
        logic [1:0] sw_sel [4];
        logic [7:0] sw_ex  [4];

        dec_in = '{8'h80, 8'h40, 8'h10, 8'hFF}; dec_ex = '{8'h40, 8'h00, 8'h00, 8'hBF};
        inc_in = '{8'h10, 8'hBF, 8'hC0, 8'hFF}; inc_ex = '{8'h50, 8'hFF, 8'hFF, 8'hFF};
        thr_in = '{8'h81, 8'h82, 8'h83, 8'h00}; thr_ex = '{8'h00, 8'h00, 8'hFF, 8'h00};
        sw_sel = '{2'b11, 2'b00, 2'b01, 2'b10}; sw_ex  = '{8'hC3, 8'h41, 8'h37, 8'hFF};

        // Reset held with the clock running and an active-looking input.
        #2;
        inbyte = 8'hAA; select = 2'b11;
        rst_n = 1'b0;
        #1;
        check("reset_async", outbyte, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("reset_hold", outbyte, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, 8'h00, 8'h00, 8'hAA, 1'b1, 8'h55, "reset_release");

        // Decrease stream with an asynchronous reset pulse after two pixels.
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 8'h40, 8'h00, dec_in[i], 1'b1, dec_ex[i], "decrease");
            if (i == 1) begin
                #2 rst_n = 1'b0;
                #1 check("midstream_reset", outbyte, 8'h00);
                #1 rst_n = 1'b1;
            end
        end

        for (int i = 0; i < 4; i++)
            drive(2'b00, 8'h40, 8'h00, inc_in[i], 1'b1, inc_ex[i], "increase");
        for (int i = 0; i < 4; i++)
            drive(2'b10, 8'h00, 8'h82, thr_in[i], 1'b1, thr_ex[i], "threshold");
        for (int i = 0; i < 4; i++)
            drive(sw_sel[i], 8'h05, 8'h3B, 8'h3C, 1'b1, sw_ex[i], "op_switch");

        // Saturation corners.
        drive(2'b00, 8'h01, 8'h00, 8'hFF, 1'b1, 8'hFF, "sat_255p1");
        drive(2'b01, 8'h01, 8'h00, 8'h00, 1'b1, 8'h00, "sat_0m1");
        drive(2'b00, 8'h00, 8'h00, 8'hFF, 1'b1, 8'hFF, "sat_255p0");
        drive(2'b01, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, "sat_0m0");
        drive(2'b00, 8'h7F, 8'h00, 8'h80, 1'b1, 8'hFF, "inc_exact_255");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++)
            drive(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  8'($urandom), 1'b0, 8'h00, "random");

        // Let the last entry drain, then verify nothing is left pending.
        @(posedge clk); #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
